instr_loader: RTL

Program loader that fills the instruction memory before the processor runs. It accepts a byte stream over a valid/ready handshake, takes a leading length byte, packs the following bytes big-endian into 32-bit instruction words, and writes each word into instruction memory at consecutive word addresses starting from 0. While loading, it holds the processor's PC in reset. It is the write-side counterpart of the PC-driven instruction fetch path.

---
 rtl/instr_loader.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// instr_loader: fills instruction memory from a byte stream before the core runs.
// A leading length byte (low ADDR_W bits, 0 meaning full depth) is followed by
// big-endian data bytes packed into 32-bit words written at word addresses 0,1,...
// While loading, cpu_hold keeps the PC in reset.
//
// Optional feature macro: LOADER_CHECKSUM_EN -- after the last word, one extra
// byte is compared against the modulo-256 sum of the data bytes; a mismatch ends
// in the ERROR state. Without it, error is constant 0.
//
// Ports:
//   clk, reset (async, active-low)
//   start                  load request pulse (honoured in IDLE/DONE/ERROR)
//   byte_in/byte_valid     stream in; byte_ready is a pure decode of state
//   mem_write/mem_addr/mem_wdata  one-cycle word write strobe with address/data
//   mem_read               instruction fetch enable, low while loading
//   cpu_hold/busy          high while a load is in progress
//   done/error             sticky result of the last load
module instr_loader #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLen   = 3'd1,
    StData  = 3'd2,
    StWrite = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    StCheck = 3'd5,
    StError = 3'd6,
`endif
    StDone  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // One extra bit so a full-depth length (2^ADDR_W) is representable.
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic hs;
  assign hs = byte_valid & byte_ready;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
`ifdef LOADER_CHECKSUM_EN
      StIdle, StDone, StError: begin
`else
      StIdle, StDone: begin
`endif
        if (start) begin
          state_d = StLen;
          addr_d  = '0;
          wcnt_d  = '0;
          bcnt_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StLen: begin
        if (hs) begin
          if (byte_in[ADDR_W-1:0] == '0) len_d = {1'b1, {ADDR_W{1'b0}}};
          else                           len_d = {1'b0, byte_in[ADDR_W-1:0]};
          state_d = StData;
        end
      end
      StData: begin
        if (hs) begin
          word_d = {word_q[23:0], byte_in};
          bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d  = sum_q + byte_in;
`endif
          if (bcnt_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        addr_d = addr_q + ADDR_W'(1);
        wcnt_d = wcnt_q + (ADDR_W + 1)'(1);
        if (wcnt_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StData;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (hs) state_d = (byte_in == sum_q) ? StDone : StError;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    byte_ready = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b1;
    cpu_hold   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state_q)
      StLen, StData: begin
        byte_ready = 1'b1;
        mem_read   = 1'b0;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
      end
      StWrite: begin
        mem_write = 1'b1;
        mem_read  = 1'b0;
        cpu_hold  = 1'b1;
        busy      = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        byte_ready = 1'b1;
        mem_read   = 1'b0;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
      end
      StError: error = 1'b1;
`endif
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;

endmodule
